// File: rtl/vib_pkg.sv
// Shared types and constants for the vibrator pulse controller.
// Mode encodings match the 2-bit mode input of vib_pulse_ctrl.
package vib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [1:0] MODE_OS    = 2'b00;
  localparam logic [1:0] MODE_OS_RT = 2'b01;
  localparam logic [1:0] MODE_AST   = 2'b10;
  localparam logic [1:0] MODE_OFF   = 2'b11;

  localparam int DEFAULT_CNT_W = 16;

endpackage

// File: rtl/vib_pulse_ctrl_rise_det.sv
// Single-bit rising-edge detector with a synchronously reset delay flop.
// RST_VAL=1 keeps a level held high across reset release from looking like an edge.
module rise_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) d_q <= RST_VAL;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/vib_pulse_ctrl.sv
// Trigger-driven one-shot / retriggerable / astable pulse sequencer.
// out, busy and trig_drop are registered from the next-state logic.
module vib_pulse_ctrl
  import vib_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             trig,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] gap,
  output logic             out,
  output logic             busy,
  output logic             trig_drop
);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       mode_q, mode_n;
  logic [CNT_W-1:0] width_q, width_n;
  logic [CNT_W-1:0] gap_q, gap_n;
  logic             drop_n;
  logic             rise;
  logic             off;

  // A zero width behaves as a one-cycle pulse, so the load value is wl-1.
  function automatic logic [CNT_W-1:0] width_load(input logic [CNT_W-1:0] w);
    return (w == '0) ? '0 : w - CNT_W'(1);
  endfunction

  rise_det #(.RST_VAL(1'b1)) u_rise_det (
    .clk  (clk),
    .rst  (rst),
    .d    (trig),
    .rise (rise)
  );

  assign off = !en || (mode == MODE_OFF);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    mode_n  = mode_q;
    width_n = width_q;
    gap_n   = gap_q;
    drop_n  = 1'b0;

    if (off) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if ((mode == MODE_AST) || rise) begin
            state_n = HIGH;
            cnt_n   = width_load(width);
            mode_n  = mode;
            width_n = width;
            gap_n   = gap;
          end
        end
        HIGH: begin
          // A retrigger reload wins over expiry in the same cycle.
          if ((mode_q == MODE_OS_RT) && rise) begin
            cnt_n = width_load(width_q);
          end else if (cnt != '0) begin
            cnt_n = cnt - CNT_W'(1);
          end else if (gap_q != '0) begin
            state_n = HOLD;
            cnt_n   = gap_q - CNT_W'(1);
          end else if (mode_q == MODE_AST) begin
            cnt_n = width_load(width_q);
          end else begin
            state_n = IDLE;
          end
          if ((mode_q == MODE_OS) && rise) drop_n = 1'b1;
        end
        HOLD: begin
          if ((mode_q != MODE_AST) && rise) drop_n = 1'b1;
          if (cnt != '0) begin
            cnt_n = cnt - CNT_W'(1);
          end else if (mode_q == MODE_AST) begin
            state_n = HIGH;
            cnt_n   = width_load(width);
            mode_n  = mode;
            width_n = width;
            gap_n   = gap;
          end else begin
            state_n = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mode_q    <= '0;
      width_q   <= '0;
      gap_q     <= '0;
      out       <= 1'b0;
      busy      <= 1'b0;
      trig_drop <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      mode_q    <= mode_n;
      width_q   <= width_n;
      gap_q     <= gap_n;
      out       <= (state_n == HIGH);
      busy      <= (state_n != IDLE);
      trig_drop <= drop_n;
    end
  end

endmodule

// File: tb/tb_vib_pulse_ctrl.sv
// Directed bench for vib_pulse_ctrl: each step pushes the expected {out,busy,trig_drop}
// for the following cycle to a scoreboard, which is popped and checked after the edge.
module tb_vib_pulse_ctrl;
  import vib_pkg::*;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [1:0]       mode;
  logic             trig;
  logic [CNT_W-1:0] width;
  logic [CNT_W-1:0] gap;
  logic             out;
  logic             busy;
  logic             trig_drop;

  int         tests_run    = 0;
  int         tests_failed = 0;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  vib_pulse_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .trig      (trig),
    .width     (width),
    .gap       (gap),
    .out       (out),
    .busy      (busy),
    .trig_drop (trig_drop)
  );

  task automatic checkOutput(input string tag);
    logic [2:0] expv;
    logic [2:0] obs;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $error("[TB] FAIL %s: scoreboard empty", tag);
      return;
    end
    expv = exp_q.pop_front();
    obs  = {out, busy, trig_drop};
    assert (obs === expv) else begin
      tests_failed++;
      $error("[TB] FAIL %s: {out,busy,trig_drop} observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic t, input logic [2:0] expv, input string tag);
    @(negedge clk);
    trig = t;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b0; mode = MODE_OS; trig = 1'b0; width = '0; gap = '0;
    applyStimulus(1'b0, 3'b000, "reset0");
    applyStimulus(1'b0, 3'b000, "reset1");
    rst = 1'b0;

    // Non-retriggerable one-shot, width 3, gap 2
    en = 1'b1; mode = MODE_OS; width = 16'd3; gap = 16'd2;
    applyStimulus(1'b0, 3'b000, "os_idle");
    applyStimulus(1'b1, 3'b110, "os_h1");
    applyStimulus(1'b0, 3'b110, "os_h2");
    applyStimulus(1'b0, 3'b110, "os_h3");
    applyStimulus(1'b0, 3'b010, "os_g1");
    applyStimulus(1'b0, 3'b010, "os_g2");
    applyStimulus(1'b0, 3'b000, "os_done");

    // Dropped triggers during HIGH and HOLD
    applyStimulus(1'b1, 3'b110, "drop_h1");
    applyStimulus(1'b0, 3'b110, "drop_h2");
    applyStimulus(1'b1, 3'b111, "drop_in_high");
    applyStimulus(1'b0, 3'b010, "drop_g1");
    applyStimulus(1'b1, 3'b011, "drop_in_hold");
    applyStimulus(1'b0, 3'b000, "drop_done");
    applyStimulus(1'b0, 3'b000, "drop_idle");

    // Retriggerable one-shot, width 4, gap 0
    mode = MODE_OS_RT; width = 16'd4; gap = 16'd0;
    applyStimulus(1'b1, 3'b110, "rt_h1");
    applyStimulus(1'b0, 3'b110, "rt_h2");
    applyStimulus(1'b1, 3'b110, "rt_reload");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'b110, "rt_hold_high");
    applyStimulus(1'b0, 3'b000, "rt_done");

    // Zero width and zero gap gives a single-cycle pulse
    mode = MODE_OS; width = 16'd0; gap = 16'd0;
    applyStimulus(1'b1, 3'b110, "w0_pulse");
    applyStimulus(1'b0, 3'b000, "w0_done");

    // Astable 2 high / 3 low, width changed to 4 mid-HIGH
    en = 1'b0; mode = MODE_AST; width = 16'd2; gap = 16'd3;
    applyStimulus(1'b0, 3'b000, "ast_off");
    en = 1'b1;
    for (int p = 0; p < 2; p++) begin
      applyStimulus(1'b0, 3'b110, "ast_h");
      applyStimulus(1'b0, 3'b110, "ast_h");
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'b010, "ast_l");
    end
    applyStimulus(1'b0, 3'b110, "ast_h");
    width = 16'd4;
    applyStimulus(1'b1, 3'b110, "ast_h_chg");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'b010, "ast_l_chg");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 3'b110, "ast_h_wide");
    en = 1'b0;
    applyStimulus(1'b0, 3'b000, "en_abort");

    // Astable with zero gap is constantly high; triggers never drop
    en = 1'b1; width = 16'd2; gap = 16'd0;
    for (int i = 0; i < 6; i++) applyStimulus(i[0], 3'b110, "ast_gap0");
    en = 1'b0;
    applyStimulus(1'b0, 3'b000, "ast_gap0_off");

    // mode=11 aborts and swallows the coincident rise without trig_drop
    en = 1'b1; mode = MODE_OS; width = 16'd5; gap = 16'd0;
    applyStimulus(1'b1, 3'b110, "off_h1");
    applyStimulus(1'b0, 3'b110, "off_h2");
    mode = MODE_OFF;
    applyStimulus(1'b1, 3'b000, "mode_off_abort");
    mode = MODE_OS;
    applyStimulus(1'b0, 3'b000, "off_idle");

    // Reset mid-pulse with trig held high through and after release
    width = 16'd3; gap = 16'd2;
    applyStimulus(1'b1, 3'b110, "rst_h1");
    applyStimulus(1'b1, 3'b110, "rst_h2");
    rst = 1'b1;
    applyStimulus(1'b1, 3'b000, "rst_assert");
    rst = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 3'b000, "rst_held_trig");
    applyStimulus(1'b0, 3'b000, "rst_trig_low");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vib_pulse_ctrl.md
Name: vib_pulse_ctrl

Overview:
- Controller that sequences a monostable/astable multivibrator from a single trigger line.
- Detects trigger rising edges and produces registered output pulses with programmable high time and hold-off/low time.
- Supports non-retriggerable one-shot, retriggerable one-shot and free-running astable modes.
- Sits between raw synchronous event inputs and downstream logic that needs clean, width-controlled strobes.

Parameters:
CNT_W, 16, width of the width/gap counters and configuration inputs

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  enable; 0 aborts any activity
mode  input  2  00 one-shot non-retrig, 01 one-shot retrig, 10 astable, 11 disabled (as en=0)
trig  input  1  trigger, already synchronous to clk
width  input  CNT_W  high time in cycles (0 treated as 1)
gap  input  CNT_W  hold-off (one-shot) or low time (astable) in cycles
out  output  1  registered pulse output
busy  output  1  high whenever state is not IDLE
trig_drop  output  1  one-cycle registered strobe, trigger edge ignored

Behaviour:
- One clock (clk); reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: state IDLE, out 0, busy 0, trig_drop 0, cnt 0, latched config 0, trig_d 1. Because trig_d resets to 1, a trig held high through reset release is not an edge.
- Edge detection: rise = trig & ~trig_d; trig_d <= trig every cycle.
- Config latch: mode, width and gap are latched on IDLE->HIGH and, in astable mode, on every HOLD->HIGH. Changes mid-pulse are ignored until then. Retrigger reloads use the latched width.
- Effective width: wl = (width==0) ? 1 : width.
- FSM states:
  - IDLE: out=0.
    - One-shot mode, en=1, rise=1 -> HIGH with cnt=wl-1.
    - Astable mode, en=1 -> HIGH with cnt=wl-1 (no trigger needed).
  - HIGH: out=1.
    - cnt!=0 -> cnt-1.
    - cnt==0 and gap!=0 -> HOLD with cnt=gap-1.
    - cnt==0, gap==0, one-shot -> IDLE.
    - cnt==0, gap==0, astable -> HIGH with reload, giving a constant high output.
    - Mode 01 with rise: cnt reloads to wl-1. This takes priority over expiry in the same cycle.
    - Mode 00 with rise: trig_drop=1 next cycle.
  - HOLD: out=0.
    - cnt!=0 -> cnt-1.
    - cnt==0 -> IDLE (one-shot) or HIGH with relatch (astable).
    - Any rise in a one-shot mode is dropped with trig_drop=1 and no pending trigger is queued.
- Latency: a rise seen in cycle N gives out=1 in cycles N+1 .. N+wl. out and busy are registered from next-state.
- en=0 or mode=11 in any state -> IDLE next cycle, out=0, busy=0; the rise in that cycle is ignored without trig_drop.
- Reset asserted mid-operation -> all outputs at reset values next cycle.
- trig_drop is never asserted in astable mode, IDLE or reset.
- Counter arithmetic is unsigned CNT_W bits and never wraps; a load always precedes any decrement past 0.

Decomposition:
- Package vib_pkg:
  - state enum IDLE/HIGH/HOLD (2-bit).
  - mode constants MODE_OS, MODE_OS_RT, MODE_AST, MODE_OFF.
  - default CNT_W.
- Sub-module rise_det: single-bit rising-edge detector with synchronous reset and parameterised reset value of the delay flop (1 here).
- FSM, counter and config latch stay in vib_pulse_ctrl.

Test Plan:
1. Non-retrig one-shot: mode=00, width=3, gap=2, trig rises cycle 10 -> out=1 cycles 11-13, busy=1 cycles 11-15, IDLE cycle 16.
2. Dropped trigger: same config, second rise in cycle 12 and third in cycle 14 -> trig_drop=1 in cycles 13 and 15; out waveform identical to scenario 1.
3. Retrigger: mode=01, width=4, gap=0, rises in cycles 10 and 12 -> out=1 cycles 11-16 (6 cycles), busy=0 from cycle 17, trig_drop never set.
4. Astable: mode=10, width=2, gap=3, en rises cycle 5 -> out pattern from cycle 6: 1,1,0,0,0 repeating (period 5). Change width to 4 mid-period -> new width takes effect from the next HOLD->HIGH.
5. Boundaries:
   - width=0, gap=0, mode=00, rise at cycle 10 -> out=1 only cycle 11, busy=0 at cycle 12.
   - Astable with gap=0 -> out constantly 1.
6. Reset and abort:
   - rst=1 in cycle 12 of scenario 1 with trig held high through cycle 20 -> out=0 and busy=0 from cycle 13; no pulse after release.
   - en=0 mid-HIGH -> out=0 next cycle.
